// File: rtl/wave_gen.sv
// Sample-rate oscillator: phase accumulator mapped to square/triangle/sawtooth,
// with mode changes deferred to a period wrap so the waveform never glitches.
module wave_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] mode,
  input  logic [7:0] step,
  output logic [7:0] sample,
  output logic       sample_valid
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CW-1:0] div_cnt_reg;
  logic [7:0]    phase_reg;
  logic          wrap_reg;
  logic [1:0]    active_mode_reg;
  logic [7:0]    sample_reg;
  logic          sample_valid_reg;

  logic          tick;
  logic [1:0]    eff_mode;
  logic [8:0]    phase_sum;
  logic [7:0]    wave_value;

  assign tick = (div_cnt_reg == CW'(SAMPLE_DIV - 1));

  // A new mode is only honoured from off, at a period wrap, or when the phase is frozen.
  always_comb begin
    eff_mode   = active_mode_reg;
    phase_sum  = {1'b0, phase_reg} + {1'b0, step};
    wave_value = 8'h80;
    if (active_mode_reg == 2'b00 || wrap_reg || step == 8'd0) begin
      eff_mode = mode;
    end
    case (eff_mode)
      2'b01:   wave_value = phase_reg[7] ? 8'h00 : 8'hFF;
      2'b10:   wave_value = phase_reg[7] ? ~{phase_reg[6:0], 1'b0} : {phase_reg[6:0], 1'b0};
      2'b11:   wave_value = phase_reg;
      default: wave_value = 8'h80;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      div_cnt_reg      <= '0;
      phase_reg        <= 8'd0;
      wrap_reg         <= 1'b0;
      active_mode_reg  <= 2'b00;
      sample_reg       <= 8'h80;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (tick) begin
        div_cnt_reg      <= '0;
        active_mode_reg  <= eff_mode;
        sample_reg       <= wave_value;
        sample_valid_reg <= 1'b1;
        if (eff_mode == 2'b00) begin
          phase_reg <= 8'd0;
          wrap_reg  <= 1'b0;
        end else begin
          {wrap_reg, phase_reg} <= phase_sum;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + CW'(1);
      end
    end
  end

  assign sample       = sample_reg;
  assign sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen: a SAMPLE_DIV=4 and a SAMPLE_DIV=1 instance share
// stimulus; an arithmetic reference model predicts every sample.
module tb_wave_gen;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] step = 8'd0;
  logic [7:0] sample4, sample1;
  logic       valid4, valid1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp4[$];
  logic [7:0] exp1[$];
  logic [7:0] obs4[$];
  logic [7:0] exp_list[$];

  int ph4, wr4, act4, cnt4;
  int ph1, wr1, act1;

  always #5 clk = ~clk;

  wave_gen #(.SAMPLE_DIV(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .mode(mode), .step(step),
    .sample(sample4), .sample_valid(valid4)
  );

  wave_gen #(.SAMPLE_DIV(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .mode(mode), .step(step),
    .sample(sample1), .sample_valid(valid1)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int wave_of(input int m, input int p);
    case (m)
      1:       return (p < 128) ? 255 : 0;
      2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      3:       return p;
      default: return 128;
    endcase
  endfunction

  // Reference: one sample tick, in plain arithmetic on the phase value.
  task automatic model_tick(inout int ph, inout int wr, inout int act,
                            input int m, input int st, output logic [7:0] smp);
    int eff;
    int s;
    eff = (act == 0 || wr != 0 || st == 0) ? m : act;
    smp = 8'(wave_of(eff, ph));
    if (eff == 0) begin
      ph = 0;
      wr = 0;
    end else begin
      s  = ph + st;
      wr = (s >= 256) ? 1 : 0;
      ph = s % 256;
    end
    act = eff;
  endtask

  // Model process: predicts samples on each clock edge the DUTs will tick.
  initial begin
    logic [7:0] smp;
    forever begin
      @(posedge clk);
      if (n_rst) begin
        ph4 = 0; wr4 = 0; act4 = 0; cnt4 = 0;
        ph1 = 0; wr1 = 0; act1 = 0;
      end else begin
        model_tick(ph1, wr1, act1, int'(mode), int'(step), smp);
        exp1.push_back(smp);
        if (cnt4 == 3) begin
          model_tick(ph4, wr4, act4, int'(mode), int'(step), smp);
          exp4.push_back(smp);
          cnt4 = 0;
        end else begin
          cnt4++;
        end
      end
    end
  end

  // Monitor: compares whenever a DUT strobes, flags strobes that are missing or extra.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (valid4) begin
        if (exp4.size() == 0) begin
          checks++; errors++;
          $display("FAIL valid4_extra: got valid=1 expected valid=0 at %0t", $time);
        end else begin
          e = exp4.pop_front();
          check("sample4", int'(sample4), int'(e));
          obs4.push_back(sample4);
        end
      end else if (exp4.size() != 0) begin
        checks++; errors++;
        $display("FAIL valid4_missing: got valid=0 expected valid=1 at %0t", $time);
        exp4.delete();
      end
      if (valid1) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL valid1_extra: got valid=1 expected valid=0 at %0t", $time);
        end else begin
          e = exp1.pop_front();
          check("sample1", int'(sample1), int'(e));
        end
      end else if (exp1.size() != 0) begin
        checks++; errors++;
        $display("FAIL valid1_missing: got valid=0 expected valid=1 at %0t", $time);
        exp1.delete();
      end
    end
  end

  // Asserts reset between edges, checks the asynchronous effect, then releases it.
  task automatic do_reset(input logic [1:0] m, input logic [7:0] st);
    @(negedge clk);
    #2 n_rst = 1'b1;
    #1;
    check("rst_sample4", int'(sample4), 8'h80);
    check("rst_valid4", int'(valid4), 0);
    check("rst_sample1", int'(sample1), 8'h80);
    check("rst_valid1", int'(valid1), 0);
    repeat (2) @(negedge clk);
    mode = m;
    step = st;
    obs4.delete();
    #2 n_rst = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 8 * n + 16 && obs4.size() < n; i++) @(negedge clk);
    if (obs4.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_obs_timeout: got %0d samples expected %0d", obs4.size(), n);
    end
  endtask

  task automatic cmp_obs(input string name);
    for (int i = 0; i < exp_list.size(); i++) begin
      if (i < obs4.size()) check(name, int'(obs4[i]), int'(exp_list[i]));
    end
  endtask

  initial begin
    int lat;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;

    // Randomized traffic; model and monitor judge every sample.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) step = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    end

    // Square from reset, reset asserted mid-period, first-strobe latency.
    do_reset(2'b01, 8'd64);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (valid4) begin
        lat = i;
        break;
      end
    end
    check("first_valid_cycle", lat, 4);
    wait_obs(6);
    exp_list = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    cmp_obs("square_seq");

    // Triangle from off.
    do_reset(2'b10, 8'd32);
    wait_obs(9);
    exp_list = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00};
    cmp_obs("triangle_seq");

    // Sawtooth step 1 across a full wrap.
    do_reset(2'b11, 8'd1);
    wait_obs(258);
    for (int i = 0; i < 258; i++) check("saw_ramp", int'(obs4[i]), i % 256);

    // Mode switch deferred to the wrap.
    do_reset(2'b01, 8'd64);
    wait_obs(2);
    mode = 2'b11;
    wait_obs(8);
    exp_list = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h40, 8'h80, 8'hC0};
    cmp_obs("deferred_switch");

    // Off at wrap, resume from off, then frozen-phase immediate adoption.
    do_reset(2'b01, 8'd64);
    wait_obs(4);
    mode = 2'b00;
    wait_obs(7);
    mode = 2'b01;
    wait_obs(8);
    mode = 2'b11;
    step = 8'd0;
    wait_obs(9);
    mode = 2'b10;
    wait_obs(10);
    exp_list = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h40, 8'h80};
    cmp_obs("off_and_frozen");

    repeat (8) @(negedge clk);
    #1;
    check("exp4_drained", exp4.size(), 0);
    check("exp1_drained", exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
